// File: rtl/wb_pflash.sv
// Wishbone B3 slave for asynchronous parallel NOR flash (8/16-bit).
// Supports incrementing/wrapping burst reads and single-lane writes.
module wb_pflash #(
  parameter int flash_size = 67108864,
  parameter int flash_dw   = 16,
  parameter int flash_aw   = $clog2(flash_size/(flash_dw/8)),
  parameter int wb_aw      = 32,
  parameter int rd_lat     = 8,
  parameter int wr_pulse   = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [wb_aw-1:0]    wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic [1:0]          wb_bte_i,
  input  logic [2:0]          wb_cti_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [31:0]         wb_dat_o,
  inout  wire  [flash_dw-1:0] fl_dat_io,
  output logic [flash_aw-1:0] fl_adr_o,
  output logic                fl_csn_o,
  output logic                fl_oen_o,
  output logic                fl_wen_o,
  output logic                fl_advn_o,
  output logic                fl_clk_o,
  output logic                fl_rstn_o
);

  localparam int beats = 32 / flash_dw;
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD       = 3'd1;
  localparam logic [2:0] WR_SETUP = 3'd2;
  localparam logic [2:0] WR_PULSE = 3'd3;
  localparam logic [2:0] WR_HOLD  = 3'd4;
  localparam logic [2:0] RESP     = 3'd5;
  localparam logic [3:0] RD_RELOAD = 4'(rd_lat - 1);
  localparam logic [3:0] WR_RELOAD = 4'(wr_pulse - 1);
  localparam logic [1:0] LAST_BEAT = 2'(beats - 1);

  logic [2:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          bidx_q, bidx_d;
  logic [wb_aw-3:0]    widx_q, widx_d;
  logic [flash_aw-1:0] adr_q, adr_d;
  logic [31-flash_dw:0] rbuf_q, rbuf_d;
  logic [31:0]         dat_q, dat_d;
  logic [flash_dw-1:0] wdat_q, wdat_d;
  logic                ack_q, ack_d, err_q, err_d, blk_q, blk_d;
  logic                csn_q, csn_d, oen_q, oen_d, wen_q, wen_d, drv_q, drv_d;

  logic                req;
  logic [31:0]         rd_cat;
  logic [wb_aw-3:0]    winc, wmask, wnext;
  logic                wr_ok;
  logic [1:0]          wr_off;
  logic [flash_dw-1:0] wr_dat;
  logic                unused_adr;

  function automatic logic [flash_aw-1:0] word2fa(input logic [wb_aw-3:0] w);
    return flash_aw'({w, 2'b00} >> ((flash_dw == 16) ? 1 : 0));
  endfunction

  // Lane k is the k-th flash word inside the 32-bit word, most significant first.
  function automatic logic [3:0] lane_mask(input int unsigned k);
    return 4'(((1 << (flash_dw/8)) - 1) << (4 - (k + 1) * (flash_dw/8)));
  endfunction

  assign unused_adr = ^wb_adr_i[1:0];
  assign rd_cat     = {rbuf_q, fl_dat_io};
  assign req        = wb_cyc_i && wb_stb_i && !ack_q && !err_q && !blk_q;

  always_comb begin
    winc = widx_q + (wb_aw-2)'(1);
    case (wb_bte_i)
      2'b01:   wmask = (wb_aw-2)'(3);
      2'b10:   wmask = (wb_aw-2)'(7);
      2'b11:   wmask = (wb_aw-2)'(15);
      default: wmask = '1;
    endcase
    wnext = (widx_q & ~wmask) | (winc & wmask);
  end

  always_comb begin
    wr_ok  = 1'b0;
    wr_off = '0;
    wr_dat = '0;
    for (int unsigned k = 0; k < beats; k++) begin
      if (wb_sel_i == lane_mask(k)) begin
        wr_ok  = 1'b1;
        wr_off = 2'(k);
        wr_dat = flash_dw'(wb_dat_i >> (32 - (k + 1) * flash_dw));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    widx_d  = widx_q;
    adr_d   = adr_q;
    rbuf_d  = rbuf_q;
    dat_d   = dat_q;
    wdat_d  = wdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          widx_d = wb_adr_i[wb_aw-1:2];
          if (!wb_we_i) begin
            state_d = RD;
            adr_d   = word2fa(wb_adr_i[wb_aw-1:2]);
            cnt_d   = RD_RELOAD;
            bidx_d  = '0;
          end else if (wr_ok) begin
            state_d = WR_SETUP;
            adr_d   = word2fa(wb_adr_i[wb_aw-1:2]) + flash_aw'(wr_off);
            wdat_d  = wr_dat;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
          end
        end
      end
      RD: begin
        // blk_q in RD marks the cycle after a burst ack: the speculative read
        // continues only if the master is still requesting a read.
        if (!wb_cyc_i || (blk_q && !(wb_stb_i && !wb_we_i))) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rbuf_d = rd_cat[31-flash_dw:0];
          cnt_d  = RD_RELOAD;
          if (bidx_q == LAST_BEAT) begin
            dat_d  = rd_cat;
            ack_d  = 1'b1;
            bidx_d = '0;
            if (wb_cti_i == 3'b010) begin
              widx_d = wnext;
              adr_d  = word2fa(wnext);
            end else begin
              state_d = IDLE;
            end
          end else begin
            bidx_d = bidx_q + 2'd1;
            adr_d  = adr_q + flash_aw'(1);
          end
        end
      end
      WR_SETUP: begin
        if (!wb_cyc_i) state_d = IDLE;
        else begin
          state_d = WR_PULSE;
          cnt_d   = WR_RELOAD;
        end
      end
      WR_PULSE: begin
        if (!wb_cyc_i)          state_d = IDLE;
        else if (cnt_q != '0)   cnt_d   = cnt_q - 4'd1;
        else                    state_d = WR_HOLD;
      end
      WR_HOLD: begin
        if (!wb_cyc_i) state_d = IDLE;
        else begin
          state_d = RESP;
          ack_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    csn_d = !((state_d inside {RD, WR_SETUP, WR_PULSE, WR_HOLD}) ||
              (state_d == RESP && !err_d));
    oen_d = (state_d != RD);
    wen_d = (state_d != WR_PULSE);
    drv_d = (state_d inside {WR_SETUP, WR_PULSE, WR_HOLD});
    blk_d = ack_q || err_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      widx_q  <= '0;
      adr_q   <= '0;
      rbuf_q  <= '0;
      dat_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      blk_q   <= 1'b0;
      csn_q   <= 1'b1;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      widx_q  <= widx_d;
      adr_q   <= adr_d;
      rbuf_q  <= rbuf_d;
      dat_q   <= dat_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      blk_q   <= blk_d;
      csn_q   <= csn_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      drv_q   <= drv_d;
    end
  end

  assign fl_dat_io = drv_q ? wdat_q : 'z;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = err_q;
  assign wb_dat_o  = dat_q;
  assign fl_adr_o  = adr_q;
  assign fl_csn_o  = csn_q;
  assign fl_oen_o  = oen_q;
  assign fl_wen_o  = wen_q;
  assign fl_advn_o = 1'b0;
  assign fl_clk_o  = 1'b0;
  assign fl_rstn_o = ~wb_rst_i;

endmodule

// File: tb/tb_wb_pflash.sv
// Bench for wb_pflash: a 16-bit and an 8-bit build share the Wishbone inputs;
// use8 routes cyc to one of them. The flash models return their word address.
module tb_wb_pflash;
  localparam int RL = 8;
  localparam int WP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we, stb, cyc, use8;
  logic [1:0]  bte;
  logic [2:0]  cti;

  logic        ack16, err16, csn16, oen16, wen16, advn16, fclk16, rstn16;
  logic [31:0] dat16;
  logic [24:0] fadr16;
  wire  [15:0] io16;
  logic        ack8, err8, csn8, oen8, wen8, advn8, fclk8, rstn8;
  logic [31:0] dat8;
  logic [25:0] fadr8;
  wire  [7:0]  io8;

  assign io16 = (!csn16 && !oen16) ? fadr16[15:0] : 'z;
  assign io8  = (!csn8 && !oen8) ? fadr8[7:0] : 'z;

  wb_pflash #(.flash_dw(16), .rd_lat(RL), .wr_pulse(WP)) dut16 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti),
    .wb_cyc_i(cyc && !use8), .wb_stb_i(stb), .wb_ack_o(ack16), .wb_err_o(err16),
    .wb_dat_o(dat16), .fl_dat_io(io16), .fl_adr_o(fadr16), .fl_csn_o(csn16),
    .fl_oen_o(oen16), .fl_wen_o(wen16), .fl_advn_o(advn16), .fl_clk_o(fclk16),
    .fl_rstn_o(rstn16));

  wb_pflash #(.flash_dw(8), .rd_lat(RL), .wr_pulse(WP)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_bte_i(bte), .wb_cti_i(cti),
    .wb_cyc_i(cyc && use8), .wb_stb_i(stb), .wb_ack_o(ack8), .wb_err_o(err8),
    .wb_dat_o(dat8), .fl_dat_io(io8), .fl_adr_o(fadr8), .fl_csn_o(csn8),
    .fl_oen_o(oen8), .fl_wen_o(wen8), .fl_advn_o(advn8), .fl_clk_o(fclk8),
    .fl_rstn_o(rstn8));

  logic        ack_s, err_s, csn_s, oen_s, wen_s;
  logic [31:0] dat_s, fadr_s;
  logic [15:0] io_s;
  assign ack_s  = use8 ? ack8 : ack16;
  assign err_s  = use8 ? err8 : err16;
  assign csn_s  = use8 ? csn8 : csn16;
  assign oen_s  = use8 ? oen8 : oen16;
  assign wen_s  = use8 ? wen8 : wen16;
  assign dat_s  = use8 ? dat8 : dat16;
  assign fadr_s = use8 ? 32'(fadr8) : 32'(fadr16);
  assign io_s   = use8 ? {8'h00, io8} : io16;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Big-endian assembly of the flash words making up one 32-bit word.
  function automatic logic [31:0] m_rd(input int dw, input logic [31:0] w);
    int nb = 32 / dw;
    logic [31:0] r = '0;
    logic [31:0] fa;
    for (int i = 0; i < nb; i++) begin
      fa = w * nb + i;
      r  = r | ((fa & ((32'd1 << dw) - 1)) << (32 - dw * (i + 1)));
    end
    return r;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] w, input logic [1:0] b);
    int blk = (b == 2'b00) ? 0 : (2 << b);
    if (blk == 0) return w + 1;
    return (w - w % blk) + (w + 1) % blk;
  endfunction

  task automatic m_wr(input int dw, input logic [3:0] s, input logic [31:0] d,
                      output logic ok, output int off, output logic [31:0] data);
    if (dw == 16) begin
      ok   = (s == 4'b1100) || (s == 4'b0011);
      off  = (s == 4'b0011) ? 1 : 0;
      data = (off == 1) ? {16'h0, d[15:0]} : {16'h0, d[31:16]};
    end else begin
      ok  = ($countones(s) == 1);
      off = 0;
      for (int i = 0; i < 4; i++) if (s[3-i]) off = i;
      data = (d >> (8 * (3 - off))) & 32'hFF;
    end
  endtask

  function automatic logic [3:0] rnd_sel(input int dw);
    if ($urandom_range(0, 2) == 0) return 4'($urandom_range(0, 15));
    if (dw == 16) return ($urandom_range(0, 1) == 1) ? 4'b1100 : 4'b0011;
    return 4'b0001 << $urandom_range(0, 3);
  endfunction

  task automatic rd(input logic [31:0] a, input int n, input logic [1:0] b);
    int dw = use8 ? 8 : 16;
    int nb = 32 / dw;
    logic [31:0] w = a >> 2;
    int c;
    logic got;
    adr = a; we = 1'b0; sel = 4'hF; bte = b;
    cti = (n > 1) ? 3'b010 : 3'b000;
    cyc = 1'b1; stb = 1'b1;
    for (int j = 0; j < n; j++) begin
      c = (j == 0) ? -1 : 0;
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
        step;
        c++;
        if (j == 0 && c == 0) chk("rd_first_adr", fadr_s, w * nb);
        if (c > 0 && c % RL == 0 && c / RL < nb) chk("rd_beat_adr", fadr_s, w * nb + c / RL);
        if (ack_s) begin
          got = 1'b1;
          chk("rd_latency", c, nb * RL);
          chk("rd_data", dat_s, m_rd(dw, w));
          chk("rd_no_err", err_s, 1'b0);
        end
      end
      chk("rd_ack_seen", got, 1'b1);
      if (j < n - 1) begin
        w   = m_next(w, b);
        adr = w << 2;
        cti = (j + 1 == n - 1) ? 3'b111 : 3'b010;
        chk("burst_next_adr", fadr_s, w * nb);
      end else begin
        cyc = 1'b0; stb = 1'b0;
      end
    end
    step;
    chk("rd_csn_idle", csn_s, 1'b1);
    chk("rd_ack_1cyc", ack_s, 1'b0);
    step;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int dw = use8 ? 8 : 16;
    int nb = 32 / dw;
    logic ok;
    int off;
    logic [31:0] ed;
    int low = 0, first = -1, ackc = -1;
    logic [31:0] wa = '0, wd = '0;
    m_wr(dw, s, d, ok, off, ed);
    adr = a; wdat = d; sel = s; we = 1'b1; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    if (!ok) begin
      step;
      chk("ill_err", err_s, 1'b1);
      chk("ill_ack", ack_s, 1'b0);
      chk("ill_csn", csn_s, 1'b1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      step;
      chk("ill_err_1cyc", err_s, 1'b0);
      chk("ill_csn2", csn_s, 1'b1);
      step;
    end else begin
      for (int k = 1; k <= 40 && ackc < 0; k++) begin
        step;
        if (!wen_s) begin
          low++;
          if (first < 0) first = k;
          wa = fadr_s;
          wd = {16'h0, io_s};
        end
        if (ack_s) ackc = k;
      end
      chk("wr_ack_cycle", ackc, 3 + WP);
      chk("wr_wen_low_cnt", low, WP);
      chk("wr_wen_first", first, 2);
      chk("wr_adr", wa, (a >> 2) * nb + off);
      chk("wr_data", wd, ed);
      chk("wr_csn_resp", csn_s, 1'b0);
      chk("wr_no_err", err_s, 1'b0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      step;
      chk("wr_ack_1cyc", ack_s, 1'b0);
      chk("wr_csn_idle", csn_s, 1'b1);
      step;
    end
  endtask

  task automatic rnd_ops(input int cnt);
    logic [31:0] ra;
    for (int i = 0; i < cnt; i++) begin
      ra = {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
      if ($urandom_range(0, 1) == 1) rd(ra, $urandom_range(1, 4), 2'($urandom_range(0, 3)));
      else wr(ra, rnd_sel(use8 ? 8 : 16), $urandom);
    end
  endtask

  int acks;
  logic got_ack;

  initial begin
    use8 = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0; bte = '0; cti = '0;
    rst = 1'b1;
    repeat (3) step;
    chk("rst_ack", ack16, 1'b0);
    chk("rst_err", err16, 1'b0);
    chk("rst_dat", dat16, 32'h0);
    chk("rst_csn", csn16, 1'b1);
    chk("rst_oen", oen16, 1'b1);
    chk("rst_wen", wen16, 1'b1);
    chk("rst_fadr", 32'(fadr16), 32'h0);
    chk("rst_rstn", rstn16, 1'b0);
    chk("rst_advn", advn16, 1'b0);
    chk("rst_fclk", fclk16, 1'b0);
    chk("rst_csn8", csn8, 1'b1);
    chk("rst_dat8", dat8, 32'h0);
    rst = 1'b0;
    step;
    chk("rstn_released", rstn16, 1'b1);

    rd(32'h100, 1, 2'b00);
    chk("single_read_value", dat16, 32'h0080_0081);
    rd(32'h0, 4, 2'b00);
    rd(32'h8, 4, 2'b01);
    rd(32'h3C, 3, 2'b10);
    rd(32'h7C, 2, 2'b11);

    wr(32'h554, 4'b0011, 32'h0000_00AA);
    wr(32'h554, 4'b1100, 32'h1234_5678);
    wr(32'h554, 4'b1111, 32'h0000_00AA);
    wr(32'h10, 4'b0000, 32'hDEAD_BEEF);

    // Read abort: cyc low during T+5.
    adr = 32'h200; we = 1'b0; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    repeat (4) step;
    cyc = 1'b0; stb = 1'b0;
    step;
    step;
    chk("abort_csn", csn16, 1'b1);
    chk("abort_oen", oen16, 1'b1);
    acks = 0;
    repeat (40) begin step; if (ack16) acks++; end
    chk("abort_no_ack", acks, 0);

    // Burst announced, then the master leaves after the first ack.
    adr = 32'h40; we = 1'b0; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    got_ack = 1'b0;
    for (int k = 0; k < 60 && !got_ack; k++) begin step; if (ack16) got_ack = 1'b1; end
    chk("spec_first_ack", got_ack, 1'b1);
    cyc = 1'b0; stb = 1'b0;
    step;
    step;
    chk("spec_drop_csn", csn16, 1'b1);
    chk("spec_drop_oen", oen16, 1'b1);
    acks = 0;
    repeat (40) begin step; if (ack16) acks++; end
    chk("spec_drop_no_ack", acks, 0);

    // Reset asserted while WE# is low.
    adr = 32'h554; sel = 4'b0011; wdat = 32'hAA; we = 1'b1; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    repeat (3) step;
    chk("rstmid_wen_low", wen16, 1'b0);
    rst = 1'b1;
    step;
    chk("rstmid_wen", wen16, 1'b1);
    chk("rstmid_csn", csn16, 1'b1);
    chk("rstmid_ack", ack16, 1'b0);
    chk("rstmid_fadr", 32'(fadr16), 32'h0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    step;
    step;

    rnd_ops(12);

    use8 = 1'b1;
    step;
    rd(32'h100, 1, 2'b00);
    chk("d8_single_value", dat8, 32'h0001_0203);
    rd(32'h4, 4, 2'b01);
    wr(32'h554, 4'b0100, 32'h00AB_0000);
    wr(32'h554, 4'b0110, 32'h00AB_0000);
    rnd_ops(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_pflash.md
# wb_pflash

Wishbone B3 slave for asynchronous parallel NOR flash: the next-generation flash controller in the orpsoc memory map. It is parametrised in flash data width (8/16 bit) and in read and write timing. It adds incrementing and wrapping burst reads and single-lane writes, so flash command sequences (program, erase, status) can be issued from software. It sits directly between the system Wishbone bus and the flash pins. Chip select is asserted only while an access is in progress.

## Interface
Parameters:
- flash_size, 67108864, flash size in bytes
- flash_dw, 16, flash data width; legal values are 8 and 16
- flash_aw, $clog2(flash_size/(flash_dw/8)), flash word-address width
- wb_aw, 32, Wishbone address width
- rd_lat, 8, cycles per read beat; address must be stable this long before sampling (2..15)
- wr_pulse, 4, cycles that WE# is held low per write (1..15)

Ports (clock and reset first):
- wb_clk_i  in  1  single clock; all logic is on its rising edge
- wb_rst_i  in  1  reset, synchronous and active-high
- wb_adr_i  in  wb_aw  byte address; bits [1:0] are ignored
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte lanes
- wb_we_i  in  1  write enable
- wb_bte_i  in  2  burst type extension: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wb_cti_i  in  3  cycle type identifier; 010 means incrementing burst
- wb_cyc_i, wb_stb_i  in  1  cycle and strobe
- wb_ack_o  out  1  one-cycle acknowledge
- wb_err_o  out  1  one-cycle error
- wb_dat_o  out  32  read data
- fl_dat_io  inout  flash_dw  flash data bus
- fl_adr_o  out  flash_aw  flash word address
- fl_csn_o, fl_oen_o, fl_wen_o  out  1  active-low chip enable, output enable, write enable
- fl_advn_o  out  1  tied 0, which keeps the flash in asynchronous mode
- fl_clk_o  out  1  tied 0
- fl_rstn_o  out  1  equal to ~wb_rst_i

## Operation
- Reset values:
  - ack=0, err=0, wb_dat_o=0
  - csn=oen=wen=1, fl_adr_o=0
  - fl_dat_io is tristated; the state machine is IDLE
- beats = 32/flash_dw (2 or 4). Reads are big-endian: the lowest flash address lands in wb_dat_o[31:32-flash_dw].
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, RESP.
- IDLE:
  - A request is cyc&stb present while ack and err are both low.
  - Read: go to RD and load fl_adr_o = adr[..:2]*beats.
  - Legal write: go to WR_SETUP.
  - Illegal write: go to RESP with err.
- RD:
  - A down-counter reloads to rd_lat-1 at each beat start.
  - At count 0 the beat is sampled into its lane, the beat index increments and fl_adr_o increments.
  - After the last beat, wb_dat_o updates and ack pulses.
- Burst continuation:
  - If cti=010 at the acking cycle, the controller stays in RD and presents the next word address during the ack cycle.
  - Next-word address: the word index increments; with wrap4/8/16 only the low 2/3/4 bits of the 32-bit word index change (wrap within the aligned block).
  - If the cycle after ack has no cyc&stb, or has we=1, the speculative read is dropped: go to IDLE, csn high, no ack.
  - Otherwise the read proceeds. The master address is not compared.
- Write lane legality:
  - flash_dw=16: sel must be 1100 or 0011. The flash address is adr[..:2]*2 + (sel==0011), and data comes from the selected halfword.
  - flash_dw=8: sel must be one-hot. Address offset and data lane follow sel (big-endian).
  - Any other sel gives err with no flash activity.
- Write sequence:
  - WR_SETUP, 1 cycle: csn=0, oen=1, data driven.
  - WR_PULSE, wr_pulse cycles: wen=0.
  - WR_HOLD, 1 cycle: wen=1, data still driven.
  - RESP: ack, then tristate the bus, csn=1, return to IDLE.
- Bus control:
  - oen=0 only in RD.
  - fl_dat_io is driven only in the WR states.
  - csn=0 in RD and the WR states, and during the RESP cycle of a write.
- Abort: cyc dropping in RD or in any WR state returns to IDLE next cycle with no ack. A write abort first forces wen=1.
- Reset mid-operation: all outputs return to their reset values on the next edge.

## Timing
- Request present in IDLE at cycle T; the flash address is valid from T+1.
- Single read: ack at T+1+beats*rd_lat. For flash_dw=16 and rd_lat=8 this is T+17.
- Burst read: each following ack comes beats*rd_lat cycles after the previous one.
- Write: ack at T+3+wr_pulse. WE# is low during T+2..T+1+wr_pulse.
- Illegal write: err at T+1.
- ack and err are never high together, and each lasts exactly 1 cycle.
- No new request is accepted in the cycle of ack or err, nor in the cycle after it.

## Test plan
- Single read: flash model returns word address as data; read byte 0x100 (dw=16, rd_lat=8) -> ack at T+17, dat=0x00800081, csn high by T+18.
- Incrementing burst: 4 words from 0x0, cti 010,010,010,111 -> four acks 16 cycles apart with consecutive data; csn high after last ack.
- Wrap4: burst starting at 0x8 -> word addresses 2,3,0,1; verify fl_adr_o sequence 4,5,6,7,0,1,2,3.
- Writes: sel=0011, dat=0x000000AA, adr 0x554 (wr_pulse=4) -> fl_adr_o=0x2AB, fl_dat_io=0xAA, wen low for exactly 4 cycles, ack at T+7. Then sel=1111 -> err at T+1, csn never low.
- Abort: drop cyc at T+5 of a read -> no ack, csn/oen high at T+6. Separately, assert wb_rst_i mid-WR_PULSE -> wen high and bus tristated on the next edge.
- dw=8 build: single read -> 4 beats, ack at T+33 with rd_lat=8, big-endian byte order.
